// File: rtl/super_pixel_pkg.sv
// rtl/super_pixel_pkg.sv - shared widths, derivations and word field offsets for the super-pixel arbiter
package super_pixel_pkg;

    localparam int N_PIX_DEF      = 8;
    localparam int TOA_W_DEF      = 9;
    localparam int FTOA_W_DEF     = 5;
    localparam int TOT_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // Word layout, LSB first: addr_col, pixel index, then {TOA, FTOA, TOT}
    localparam int COL_LSB = 0;
    localparam int IDX_LSB = 1;

    function automatic int pix_aw(input int n_pix);
        return $clog2(n_pix);
    endfunction

    function automatic int pix_dw(input int toa_w, input int ftoa_w, input int tot_w);
        return toa_w + ftoa_w + tot_w;
    endfunction

    function automatic int data_w(input int n_pix, input int toa_w, input int ftoa_w, input int tot_w);
        return pix_dw(toa_w, ftoa_w, tot_w) + pix_aw(n_pix) + 1;
    endfunction

    // LSB of the TOT field, which is also the base of the whole pixel payload
    function automatic int tot_lsb(input int n_pix);
        return IDX_LSB + pix_aw(n_pix);
    endfunction

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_LOCAL = 2'd1,
        SRC_UP    = 2'd2
    } src_e;

endpackage

// File: rtl/sp_sync_fifo.sv
// rtl/sp_sync_fifo.sv - single-clock FIFO with registered memory and full/empty/level flags
module sp_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign rd_ok   = rd_en && !empty;
    // a write into a full FIFO is fine when the same edge frees a slot
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    // storage array; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/super_pixel_arbiter_n.sv
// rtl/super_pixel_arbiter_n.sv - round-robin pixel arbiter with local FIFO and chained output stage
module super_pixel_arbiter_n
    import super_pixel_pkg::*;
#(
    parameter int N_PIX      = N_PIX_DEF,
    parameter int TOA_W      = TOA_W_DEF,
    parameter int FTOA_W     = FTOA_W_DEF,
    parameter int TOT_W      = TOT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                                          clk_40MHz,
    input  logic                                          rst_n,
    input  logic                                          shutter,
    input  logic                                          mode,
    input  logic                                          addr_col,
    input  logic [N_PIX-1:0]                              pix_req,
    input  logic [N_PIX*(TOA_W+FTOA_W+TOT_W)-1:0]         pix_data,
    output logic [N_PIX-1:0]                              pix_ack,
    input  logic [TOA_W+FTOA_W+TOT_W+$clog2(N_PIX):0]     last_data,
    input  logic                                          last_valid,
    output logic                                          shake_hands_last,
    output logic [TOA_W+FTOA_W+TOT_W+$clog2(N_PIX):0]     arbiter_data,
    output logic                                          arbiter_valid,
    input  logic                                          shake_hands_next,
    output logic [$clog2(FIFO_DEPTH):0]                   fifo_level
);
    localparam int PIX_AW  = pix_aw(N_PIX);
    localparam int PIX_DW  = pix_dw(TOA_W, FTOA_W, TOT_W);
    localparam int DATA_W  = data_w(N_PIX, TOA_W, FTOA_W, TOT_W);
    localparam int TOT_LSB = tot_lsb(N_PIX);

    logic [N_PIX-1:0]  req_m;
    logic [PIX_AW-1:0] last_grant;
    logic [PIX_AW-1:0] grant_idx;
    logic              grant_vld;
    logic              grant_en;
    logic [DATA_W-1:0] local_word;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd;
    logic              out_load;
    logic              favour_up;
    src_e              src_sel;

    // a pixel being acknowledged this cycle may still show its request; ignore it
    assign req_m    = pix_req & ~pix_ack;
    assign grant_en = grant_vld && !shutter && !fifo_full;

    // round-robin search starting one above the previous grant, wrapping at N_PIX
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_PIX; k++) begin
            if (!grant_vld && req_m[last_grant + PIX_AW'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = last_grant + PIX_AW'(k);
            end
        end
    end

    // assemble {TOA, FTOA, TOT, index, addr_col} for the granted pixel
    always_comb begin
        local_word                     = '0;
        local_word[COL_LSB]            = addr_col;
        local_word[IDX_LSB +: PIX_AW]  = grant_idx;
        local_word[TOT_LSB +: PIX_DW]  = pix_data[grant_idx*PIX_DW +: PIX_DW];
    end

    // one-cycle acknowledge and round-robin pointer; reset leaves pixel 0 first in line
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            pix_ack    <= '0;
            last_grant <= '1;
        end else begin
            pix_ack <= grant_en ? (N_PIX'(1) << grant_idx) : '0;
            if (grant_en) begin
                last_grant <= grant_idx;
            end
        end
    end

    sp_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_40MHz),
        .rst_n   (rst_n),
        .wr_en   (grant_en),
        .wr_data (local_word),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_load = !arbiter_valid || shake_hands_next;

    // pick the output source; in alternate mode a contested load goes against the last winner
    always_comb begin
        src_sel = SRC_NONE;
        if (!fifo_empty && last_valid) begin
            src_sel = (mode && favour_up) ? SRC_UP : SRC_LOCAL;
        end else if (!fifo_empty) begin
            src_sel = SRC_LOCAL;
        end else if (last_valid) begin
            src_sel = SRC_UP;
        end
    end

    assign fifo_rd          = out_load && (src_sel == SRC_LOCAL);
    assign shake_hands_last = rst_n && out_load && (src_sel == SRC_UP);

    // output register and the record of which source won the last load
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            arbiter_valid <= 1'b0;
            arbiter_data  <= '0;
            favour_up     <= 1'b0;
        end else if (out_load) begin
            case (src_sel)
                SRC_LOCAL: begin
                    arbiter_valid <= 1'b1;
                    arbiter_data  <= fifo_rdata;
                    favour_up     <= 1'b1;
                end
                SRC_UP: begin
                    arbiter_valid <= 1'b1;
                    arbiter_data  <= last_data;
                    favour_up     <= 1'b0;
                end
                default: begin
                    arbiter_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_super_pixel_arbiter_n.sv
// tb/tb_super_pixel_arbiter_n.sv - directed and random checks of super_pixel_arbiter_n against a queue model
module tb_super_pixel_arbiter_n;
    localparam int N     = 8;
    localparam int AW    = 3;
    localparam int DW    = 22;
    localparam int W     = 26;
    localparam int DEPTH = 4;

    logic            clk_40MHz = 1'b0;
    logic            rst_n;
    logic            shutter;
    logic            mode;
    logic            addr_col;
    logic [N-1:0]    pix_req;
    logic [N*DW-1:0] pix_data;
    logic [N-1:0]    pix_ack;
    logic [W-1:0]    last_data;
    logic            last_valid;
    logic            shake_hands_last;
    logic [W-1:0]    arbiter_data;
    logic            arbiter_valid;
    logic            shake_hands_next;
    logic [2:0]      fifo_level;

    super_pixel_arbiter_n dut (
        .clk_40MHz        (clk_40MHz),
        .rst_n            (rst_n),
        .shutter          (shutter),
        .mode             (mode),
        .addr_col         (addr_col),
        .pix_req          (pix_req),
        .pix_data         (pix_data),
        .pix_ack          (pix_ack),
        .last_data        (last_data),
        .last_valid       (last_valid),
        .shake_hands_last (shake_hands_last),
        .arbiter_data     (arbiter_data),
        .arbiter_valid    (arbiter_valid),
        .shake_hands_next (shake_hands_next),
        .fifo_level       (fifo_level)
    );

    always #10 clk_40MHz = ~clk_40MHz;

    int tests = 0;
    int fails = 0;

    // pixel stimulus
    logic [N-1:0]  req_v;
    logic [DW-1:0] hit_data [N];
    bit            auto_drop;

    // reference model state
    logic [W-1:0]  m_fifo [$];
    bit            m_ov;
    logic [W-1:0]  m_od;
    int            m_last;
    int            m_ack;
    bit            m_prev_local;
    int            m_grant;
    int            m_src;
    bit            m_load;
    bit            m_shl;

    // observed DUT activity counters
    int            dut_acks;
    int            dut_words;
    int            up_hs;
    logic [N-1:0]  seen_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            pix_req[i]              = req_v[i];
            pix_data[i*DW +: DW]    = hit_data[i];
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_ov         = 1'b0;
        m_od         = '0;
        m_last       = N - 1;
        m_ack        = -1;
        m_prev_local = 1'b0;
    endfunction

    // decisions made during the cycle from the rules: grant, output source, upstream ready
    function automatic void model_comb();
        int g = -1;
        if (!shutter && m_fifo.size() < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (g < 0 && pix_req[c] && m_ack != c) g = c;
            end
        end
        m_grant = g;
        m_load  = !m_ov || shake_hands_next;
        if (m_fifo.size() > 0 && last_valid) m_src = (mode && m_prev_local) ? 2 : 1;
        else if (m_fifo.size() > 0)          m_src = 1;
        else if (last_valid)                 m_src = 2;
        else                                 m_src = 0;
        m_shl = m_load && (m_src == 2);
    endfunction

    function automatic void model_edge();
        if (m_load) begin
            if (m_src == 1) begin
                m_od = m_fifo.pop_front();
                m_ov = 1'b1;
                m_prev_local = 1'b1;
            end else if (m_src == 2) begin
                m_od = last_data;
                m_ov = 1'b1;
                m_prev_local = 1'b0;
            end else begin
                m_ov = 1'b0;
            end
        end
        if (m_grant >= 0) begin
            m_fifo.push_back({hit_data[m_grant], 3'(m_grant), addr_col});
            m_last = m_grant;
        end
        m_ack = m_grant;
    endfunction

    task automatic cycle();
        bit hs;
        drive();
        #1;
        model_comb();
        check("shake_hands_last", {63'd0, shake_hands_last}, {63'd0, m_shl});
        hs = m_shl && last_valid;
        if (arbiter_valid && shake_hands_next) begin
            dut_words++;
            seen_idx[arbiter_data[3:1]] = 1'b1;
        end
        if (shake_hands_last && last_valid) up_hs++;
        @(posedge clk_40MHz);
        model_edge();
        #1;
        check("pix_ack", {56'd0, pix_ack}, (m_ack >= 0) ? (64'd1 << m_ack) : 64'd0);
        check("arbiter_valid", {63'd0, arbiter_valid}, {63'd0, m_ov});
        if (m_ov) check("arbiter_data", {38'd0, arbiter_data}, {38'd0, m_od});
        check("fifo_level", {61'd0, fifo_level}, 64'(m_fifo.size()));
        for (int i = 0; i < N; i++) dut_acks += int'(pix_ack[i]);
        if (m_ack >= 0 && auto_drop) begin
            req_v[m_ack]    = 1'b0;
            hit_data[m_ack] = DW'($urandom);
        end
        if (hs) last_data = W'($urandom);
    endtask

    task automatic do_reset();
        logic lv_save;
        lv_save    = last_valid;
        last_valid = 1'b1;
        drive();
        rst_n = 1'b0;
        #1;
        check("rst pix_ack", {56'd0, pix_ack}, 64'd0);
        check("rst arbiter_valid", {63'd0, arbiter_valid}, 64'd0);
        check("rst arbiter_data", {38'd0, arbiter_data}, 64'd0);
        check("rst fifo_level", {61'd0, fifo_level}, 64'd0);
        check("rst shake_hands_last", {63'd0, shake_hands_last}, 64'd0);
        model_reset();
        repeat (2) @(posedge clk_40MHz);
        #1;
        check("rst held arbiter_valid", {63'd0, arbiter_valid}, 64'd0);
        rst_n      = 1'b1;
        last_valid = lv_save;
    endtask

    initial begin
        int a0, w0, h0, low, ia, ib, ir;
        logic [N-1:0] bp_set;

        rst_n = 1'b0; shutter = 1'b0; mode = 1'b0; addr_col = 1'b0;
        last_valid = 1'b0; last_data = '0; shake_hands_next = 1'b1;
        req_v = '0; auto_drop = 1'b1;
        dut_acks = 0; dut_words = 0; up_hs = 0; seen_idx = '0;
        for (int i = 0; i < N; i++) hit_data[i] = '0;
        drive();
        do_reset();

        // single hit on pixel 3
        addr_col    = 1'b1;
        hit_data[3] = {9'h0A5, 5'h11, 8'h3C};
        req_v[3]    = 1'b1;
        cycle();
        check("single ack", {56'd0, pix_ack}, 64'h08);
        check("single not yet valid", {63'd0, arbiter_valid}, 64'd0);
        cycle();
        check("single valid", {63'd0, arbiter_valid}, 64'd1);
        check("single data", {38'd0, arbiter_data}, {38'd0, 9'h0A5, 5'h11, 8'h3C, 3'd3, 1'b1});
        repeat (2) cycle();

        // fairness with every pixel holding its request
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++) begin req_v[i] = 1'b1; hit_data[i] = DW'($urandom); end
        for (int c = 0; c < 9; c++) begin
            cycle();
            check("fair ack order", {56'd0, pix_ack}, 64'd1 << (c % 8));
        end
        req_v = '0; auto_drop = 1'b1;
        repeat (4) cycle();

        // backpressure with six requesters
        shake_hands_next = 1'b0;
        ia = $urandom_range(N-1);
        ib = (ia + 1 + $urandom_range(N-2)) % N;
        bp_set = '1; bp_set[ia] = 1'b0; bp_set[ib] = 1'b0;
        for (int i = 0; i < N; i++) begin req_v[i] = bp_set[i]; hit_data[i] = DW'($urandom); end
        a0 = dut_acks;
        repeat (8) cycle();
        check("bp acks while stalled", 64'(dut_acks - a0), 64'd5);
        check("bp fifo full", {61'd0, fifo_level}, 64'd4);
        w0 = dut_words; seen_idx = '0;
        shake_hands_next = 1'b1;
        repeat (10) cycle();
        check("bp total acks", 64'(dut_acks - a0), 64'd6);
        check("bp words out", 64'(dut_words - w0), 64'd6);
        check("bp indices", {56'd0, seen_idx}, {56'd0, bp_set});

        // mode 0 chain with shutter closed and one request left pending
        shake_hands_next = 1'b0;
        for (int i = 0; i < 6; i++) begin req_v[i] = 1'b1; hit_data[i] = DW'($urandom); end
        repeat (7) cycle();
        check("chain fill level", {61'd0, fifo_level}, 64'd4);
        shutter = 1'b1; mode = 1'b0; last_valid = 1'b1; last_data = W'($urandom);
        shake_hands_next = 1'b1;
        a0 = dut_acks; h0 = up_hs;
        repeat (4) cycle();
        check("mode0 local first", 64'(up_hs - h0), 64'd0);
        repeat (4) cycle();
        check("mode0 upstream after empty", 64'(up_hs - h0), 64'd4);
        check("shutter no ack", 64'(dut_acks - a0), 64'd0);
        shutter = 1'b0;
        cycle();
        check("shutter resume", {63'd0, (pix_ack != '0)}, 64'd1);

        // mode 1 strict alternation
        last_valid = 1'b0; shake_hands_next = 1'b0;
        for (int i = 0; i < 6; i++) if (!req_v[i]) begin req_v[i] = 1'b1; hit_data[i] = DW'($urandom); end
        repeat (7) cycle();
        check("alt fill level", {61'd0, fifo_level}, 64'd4);
        mode = 1'b1; shutter = 1'b1; last_valid = 1'b1; shake_hands_next = 1'b1;
        h0 = up_hs;
        repeat (6) cycle();
        check("mode1 alternation", 64'(up_hs - h0), 64'd3);
        last_valid = 1'b0; shutter = 1'b0;
        repeat (14) cycle();

        // reset in the middle of a burst
        shake_hands_next = 1'b0; mode = 1'b0;
        for (int i = 0; i < N; i++) if (!req_v[i]) begin req_v[i] = 1'b1; hit_data[i] = DW'($urandom); end
        repeat (4) cycle();
        check("burst level", {61'd0, fifo_level}, 64'd3);
        do_reset();
        low = -1;
        for (int i = N - 1; i >= 0; i--) if (req_v[i]) low = i;
        cycle();
        check("post-reset first grant", {56'd0, pix_ack}, (low >= 0) ? (64'd1 << low) : 64'd0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(2) == 0) begin
                ir = $urandom_range(N-1);
                if (!req_v[ir]) begin req_v[ir] = 1'b1; hit_data[ir] = DW'($urandom); end
            end
            shake_hands_next = ($urandom_range(3) != 0);
            last_valid       = ($urandom_range(2) == 0);
            shutter          = ($urandom_range(15) == 0);
            addr_col         = 1'($urandom_range(1));
            if ($urandom_range(31) == 0) mode = ~mode;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
